// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse generator.
package pulse_gen_pkg;

  // Default operand / counter width.
  localparam int unsigned PG_CNT_W = 32;

  // Pulse generator phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } pg_state_e;

endpackage

// File: rtl/pulse_gen_counter.sv
// Loadable down-counter shared by the DELAY, HIGH and LOW phases.
// Loaded with N-1 on phase entry; tc is high when the count reaches zero.
module pulse_gen_counter
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = PG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse train generator: delay, width and period are latched
// on a rising edge of pulse_start and the train runs while pulse_start stays high.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = PG_CNT_W
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             pulse_start,
  input  logic [CNT_W-1:0] pulse_delay,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_repetition,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count,
  output logic             cfg_error
);

  pg_state_e        state_q;
  pg_state_e        state_d;

  logic             start_q;
  // Set once pulse_start has been seen low since reset, so a level held
  // high through reset release is not mistaken for a rising edge.
  logic             armed_q;
  logic             trigger;

  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] rep_q;
  logic             rep_bad;

  logic             run_start;
  logic             enter_high;
  logic             cfg_err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_tc;

  assign trigger = pulse_start && !start_q && armed_q;
  assign rep_bad = (pulse_repetition != '0) && (pulse_repetition <= pulse_width);

  pulse_gen_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  // Next-state decode and phase-counter control.
  always_comb begin
    state_d      = state_q;
    run_start    = 1'b0;
    enter_high   = 1'b0;
    cfg_err_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (pulse_width == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            run_start = 1'b1;
            cfg_err_d = rep_bad;
            cnt_load  = 1'b1;
            if (pulse_delay == '0) begin
              state_d      = ST_HIGH;
              enter_high   = 1'b1;
              cnt_load_val = pulse_width - CNT_W'(1);
            end else begin
              state_d      = ST_DELAY;
              cnt_load_val = pulse_delay - CNT_W'(1);
            end
          end
        end
      end

      ST_DELAY, ST_LOW: begin
        // Abort wins over the terminal count: no pulse after a drop.
        if (!pulse_start) begin
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          state_d      = ST_HIGH;
          enter_high   = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = width_q - CNT_W'(1);
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_HIGH: begin
        // pulse_start is only looked at here, so a pulse is never cut short.
        if (cnt_tc) begin
          if ((rep_q == '0) || !pulse_start) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_LOW;
            cnt_load     = 1'b1;
            cnt_load_val = rep_q - width_q - CNT_W'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      width_q     <= '0;
      rep_q       <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      pulse_count <= '0;
      cfg_error   <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= pulse_start;
      armed_q   <= armed_q || !pulse_start;
      pulse_out <= (state_d == ST_HIGH);
      busy      <= (state_d != ST_IDLE);
      cfg_error <= cfg_err_d;

      if (run_start) begin
        width_q <= pulse_width;
        // An unusable period degrades the run to a single shot.
        rep_q   <= rep_bad ? '0 : pulse_repetition;
      end

      if (run_start) begin
        pulse_count <= enter_high ? CNT_W'(1) : '0;
      end else if (enter_high && (pulse_count != '1)) begin
        pulse_count <= pulse_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: a timing model predicts every pulse
// (rise edge, width, count) and cfg_error strobe; a monitor pops and compares.
module tb_pulse_gen;

  localparam int unsigned CW   = 8;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_reset = 1'b1;
  logic          pulse_start = 1'b0;
  logic [CW-1:0] pulse_delay = '0;
  logic [CW-1:0] pulse_width = '0;
  logic [CW-1:0] pulse_repetition = '0;
  logic          pulse_out;
  logic          busy;
  logic [CW-1:0] pulse_count;
  logic          cfg_error;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int rise;
    int width;
    int cnt;
  } pulse_t;

  pulse_t exp_q[$];
  int     cfg_q[$];

  pulse_gen #(.CNT_W(CW)) dut (
    .clk_clk          (clk),
    .reset_reset      (reset_reset),
    .pulse_start      (pulse_start),
    .pulse_delay      (pulse_delay),
    .pulse_width      (pulse_width),
    .pulse_repetition (pulse_repetition),
    .pulse_out        (pulse_out),
    .busy             (busy),
    .pulse_count      (pulse_count),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  // Monitor: measure each pulse and each cfg_error strobe, compare with queue heads.
  bit     in_pulse = 1'b0;
  int     rise_e, cur_w, cnt_rise, cfg_e;
  pulse_t e_p;

  always @(negedge clk) begin
    if (pulse_out) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        rise_e   = edge_n;
        cur_w    = 0;
        cnt_rise = int'(pulse_count);
      end
      cur_w++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got rise=%0d width=%0d count=%0d, required no pulse",
                 rise_e, cur_w, cnt_rise);
      end else begin
        e_p = exp_q.pop_front();
        if (e_p.rise != rise_e || e_p.width != cur_w || e_p.cnt != cnt_rise) begin
          errors++;
          $display("FAIL pulse: got rise=%0d width=%0d count=%0d, required rise=%0d width=%0d count=%0d",
                   rise_e, cur_w, cnt_rise, e_p.rise, e_p.width, e_p.cnt);
        end
      end
    end
    if (cfg_error) begin
      checks++;
      if (cfg_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_error_unexpected: got strobe at edge %0d, required none", edge_n);
      end else begin
        cfg_e = cfg_q.pop_front();
        if (cfg_e != edge_n) begin
          errors++;
          $display("FAIL cfg_error_edge: got %0d required %0d", edge_n, cfg_e);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Reference model. Trigger sampled at edge t0, pulse_start first sampled low
  // at edge t0+drop. Pulse k enters HIGH at edge t0+d+k*period and exists only
  // if pulse_start was still high at that edge; a bad period means one shot.
  function automatic int push_model(input int t0, input int d, input int w,
                                    input int r, input int drop);
    int n, rr, rk, td;
    n  = 0;
    td = t0 + drop;
    if (w == 0 || (r != 0 && r <= w)) cfg_q.push_back(t0);
    if (w == 0) return 0;
    rr = (r > w) ? r : 0;
    for (int k = 0; k < 100000; k++) begin
      rk = t0 + d + k * rr;
      if (rk >= td) break;
      if (k > 0 && rr == 0) break;
      exp_q.push_back(pulse_t'{rise: rk, width: w, cnt: (k + 1 < MAXC) ? k + 1 : MAXC});
      n++;
    end
    return n;
  endfunction

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic run_scn(input string name, input int d, input int w, input int r,
                         input int drop, input int new_w);
    int t0, n;
    @(negedge clk);
    pulse_delay      = CW'(d);
    pulse_width      = CW'(w);
    pulse_repetition = CW'(r);
    pulse_start      = 1'b1;
    t0 = edge_n + 1;
    n  = push_model(t0, d, w, r, drop);
    @(negedge clk);
    check({name, " busy_after_trigger"}, int'(busy), (w != 0) ? 1 : 0);
    if (new_w >= 0) pulse_width = CW'(new_w);
    repeat (drop - 1) @(negedge clk);
    pulse_start = 1'b0;
    wait_idle(64);
    @(negedge clk);
    check({name, " missing_pulses"}, exp_q.size(), 0);
    check({name, " missing_cfg_error"}, cfg_q.size(), 0);
    if (w != 0) check({name, " pulse_count"}, int'(pulse_count), (n < MAXC) ? n : MAXC);
    exp_q.delete();
    cfg_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int t0, d, w, r, drop;

    repeat (3) @(negedge clk);
    check("reset pulse_out", int'(pulse_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset pulse_count", int'(pulse_count), 0);
    check("reset cfg_error", int'(cfg_error), 0);
    reset_reset = 1'b0;
    repeat (2) @(negedge clk);

    run_scn("single_d0_w3", 0, 3, 0, 10, -1);
    run_scn("train_d5_w2_r10", 5, 2, 10, 50, -1);
    run_scn("drop_mid_high_p3", 5, 2, 10, 26, -1);
    run_scn("width_zero", 2, 0, 0, 8, -1);
    run_scn("rep_eq_width", 1, 4, 4, 20, -1);
    run_scn("delay_abort", 6, 3, 0, 4, -1);
    run_scn("low_abort", 0, 2, 9, 6, -1);
    run_scn("width_change", 1, 2, 6, 30, 7);
    run_scn("retrigger_w7", 0, 7, 10, 25, -1);

    // Reset in the middle of a pulse, with pulse_start held high across it.
    @(negedge clk);
    pulse_delay      = CW'(0);
    pulse_width      = CW'(5);
    pulse_repetition = CW'(8);
    pulse_start      = 1'b1;
    t0 = edge_n + 1;
    exp_q.push_back(pulse_t'{rise: t0, width: 2, cnt: 1});
    repeat (2) @(negedge clk);
    reset_reset = 1'b1;
    @(negedge clk);
    check("midreset pulse_out", int'(pulse_out), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset pulse_count", int'(pulse_count), 0);
    check("midreset cfg_error", int'(cfg_error), 0);
    reset_reset = 1'b0;
    repeat (20) @(negedge clk);
    check("held_start busy", int'(busy), 0);
    check("held_start pulses", exp_q.size(), 0);
    exp_q.delete();
    pulse_start = 1'b0;
    repeat (2) @(negedge clk);
    run_scn("after_reset", 0, 2, 0, 5, -1);

    run_scn("saturate", 0, 1, 2, 600, -1);

    for (int i = 0; i < 25; i++) begin
      d    = $urandom_range(0, 4);
      w    = $urandom_range(0, 4);
      r    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 10);
      drop = $urandom_range(1, 40);
      run_scn($sformatf("rand%0d", i), d, w, r, drop, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
